// File: rtl/uart_pkg.sv
// Shared types for the UART transmit queue.
// Byte width and the launch sequencer states.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    TXQ_IDLE      = 2'd0,
    TXQ_LAUNCH    = 2'd1,
    TXQ_WAIT_BUSY = 2'd2,
    TXQ_WAIT_DONE = 2'd3
  } uart_txq_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Host write port and UART launch bundle.
// master = host/UART side, slave = queue.
interface uart_tx_queue_if #(
  parameter int DEPTH = 16
) ();
  import uart_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   full;
  logic                   empty;
  logic [CW-1:0]          count;
  logic                   overflow;
  logic                   start_err;
  logic                   tx_busy;
  logic                   tx_start;
  logic [UART_DATA_W-1:0] tx_data;

  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, count,
    input  overflow, start_err,
    input  tx_start, tx_data
  );

  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, count,
    output overflow, start_err,
    output tx_start, tx_data
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered flags.
// Storage is left unreset; pointers wrap.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  // Next pointers, occupancy and flags from the same count.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    count_d = count_q + CW'(do_push)
                      - CW'(do_pop);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer and flag state.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Byte storage.
  always_ff @(posedge pclk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and launch sequencer for a UART.
// One tx_start pulse per frame, gated by tx_busy.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic               pclk,
  input logic               reset,
  uart_tx_queue_if.slave    bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  uart_txq_state_t        state_q, state_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   ovf_q, ovf_d;
  logic                   err_q, err_d;

  logic                   push, pop;
  logic [UART_DATA_W-1:0] head;
  logic                   f_full, f_empty;
  logic [CW-1:0]          f_count;

  assign push = bus.wr_en && !f_full;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .pclk  (pclk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.wr_data),
    .dout  (head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // Launch sequencer, timeout and sticky errors.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = err_q;
    ovf_d      = ovf_q | (bus.wr_en & f_full);
    pop        = 1'b0;
    unique case (state_q)
      TXQ_IDLE: begin
        if (!f_empty && !bus.tx_busy) begin
          state_d    = TXQ_LAUNCH;
          pop        = 1'b1;
          tx_data_d  = head;
          tx_start_d = 1'b1;
        end
      end
      TXQ_LAUNCH: begin
        state_d = TXQ_WAIT_BUSY;
        tmo_d   = '0;
      end
      TXQ_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = TXQ_WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d = TXQ_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      TXQ_WAIT_DONE: begin
        if (!bus.tx_busy) state_d = TXQ_IDLE;
      end
      default: state_d = TXQ_IDLE;
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q    <= TXQ_IDLE;
      tmo_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign bus.full      = f_full;
  assign bus.empty     = f_empty;
  assign bus.count     = f_count;
  assign bus.overflow  = ovf_q;
  assign bus.start_err = err_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue with a small UART
// busy model and directed vector tables.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 16;
  localparam int FRAME        = 10;

  logic pclk  = 1'b0;
  logic reset = 1'b0;

  uart_tx_queue_if #(.DEPTH(DEPTH)) bus();

  uart_tx_queue #(
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  logic       use_model;
  logic       f_busy;
  logic       m_busy;
  int         m_cnt;
  logic [7:0] m_byte;
  logic [7:0] rxq [$];

  assign bus.tx_busy = use_model ? m_busy : f_busy;

  // Simple UART: busy for FRAME cycles, byte delivered at frame end.
  always @(posedge pclk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (bus.tx_start === 1'b1) begin
        m_busy <= 1'b1;
        m_cnt  <= FRAME - 1;
        m_byte <= bus.tx_data;
      end
    end else if (m_cnt == 0) begin
      m_busy <= 1'b0;
      rxq.push_back(m_byte);
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  int   ecnt = 0;
  int   start_e [$];
  int   fall_e [$];
  logic prev_start = 1'b0;
  logic prev_busy  = 1'b0;
  int   consec = 0;

  always @(posedge pclk) ecnt++;

  always @(negedge pclk) begin
    if (bus.tx_start === 1'b1 && prev_start !== 1'b1)
      start_e.push_back(ecnt);
    if (bus.tx_start === 1'b1 && prev_start === 1'b1)
      consec++;
    if (prev_busy === 1'b1 && bus.tx_busy === 1'b0)
      fall_e.push_back(ecnt);
    prev_start = bus.tx_start;
    prev_busy  = bus.tx_busy;
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    logic       busy;
    logic [4:0] e_count;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
    logic       e_start;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge pclk);
    #3;
    reset = 1'b0;
    rxq.delete();
    start_e.delete();
    fall_e.delete();
    consec = 0;
    tick();
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_rx(input string nm,
                         input int n,
                         input int budget);
    int b;
    b = 0;
    while (rxq.size() < n && b < budget) begin
      tick();
      b++;
    end
    checks++;
    if (rxq.size() < n) begin
      errors++;
      $display("FAIL %s: received %0d bytes, expected %0d",
               nm, rxq.size(), n);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    if (i < rxq.size()) return rxq[i];
    return 8'hxx;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    use_model   = 1'b1;
    f_busy      = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;

    // Asynchronous reset values, before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_start_err", 32'(bus.start_err), 0);

    // Single byte, write-to-launch latency.
    do_reset();
    wr(8'hA5);
    chk("one_count_k", 32'(bus.count), 1);
    chk("one_empty_k", 32'(bus.empty), 0);
    chk("one_start_k", 32'(bus.tx_start), 0);
    tick();
    chk("one_start_k1", 32'(bus.tx_start), 1);
    chk("one_data_k1", 32'(bus.tx_data), 32'hA5);
    chk("one_count_k1", 32'(bus.count), 0);
    chk("one_empty_k1", 32'(bus.empty), 1);
    tick();
    chk("one_start_k2", 32'(bus.tx_start), 0);
    chk("one_data_k2", 32'(bus.tx_data), 32'hA5);
    wait_rx("one_rx_wait", 1, 100);
    chk("one_rx", 32'(rx_at(0)), 32'hA5);
    repeat (4) tick();
    chk("one_empty_end", 32'(bus.empty), 1);
    chk("one_count_end", 32'(bus.count), 0);
    chk("one_n_starts", start_e.size(), 1);

    // Burst of four, back-to-back frames.
    do_reset();
    for (int i = 1; i <= 4; i++) wr(8'(i));
    wait_rx("burst_rx_wait", 4, 300);
    repeat (4) tick();
    chk("burst_n_starts", start_e.size(), 4);
    chk("burst_n_falls", fall_e.size(), 4);
    for (int i = 0; i < 3; i++) begin
      if (i + 1 < start_e.size() && i < fall_e.size())
        chk($sformatf("burst_gap%0d", i),
            start_e[i+1] - fall_e[i], 2);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("burst_rx%0d", i),
          32'(rx_at(i)), i + 1);
    chk("burst_consec", consec, 0);

    // Push and pop in the same cycle at count 3.
    do_reset();
    use_model = 1'b0;
    f_busy    = 1'b1;
    wr(8'h10);
    wr(8'h11);
    wr(8'h12);
    chk("pp_count_pre", 32'(bus.count), 3);
    chk("pp_held_off", 32'(bus.tx_start), 0);
    f_busy      = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h13;
    tick();
    bus.wr_en = 1'b0;
    use_model = 1'b1;
    chk("pp_count", 32'(bus.count), 3);
    chk("pp_start", 32'(bus.tx_start), 1);
    chk("pp_data", 32'(bus.tx_data), 32'h10);
    wait_rx("pp_rx_wait", 4, 300);
    for (int i = 0; i < 4; i++)
      chk($sformatf("pp_rx%0d", i),
          32'(rx_at(i)), 32'h10 + i);

    // Fill and overflow with tx_busy held high.
    for (int i = 0; i < 17; i++) begin
      vt[i].wr_en   = 1'b1;
      vt[i].data    = 8'(8'h20 + i);
      vt[i].busy    = 1'b1;
      vt[i].e_count = (i < 16) ? 5'(i + 1) : 5'd16;
      vt[i].e_full  = (i >= 15);
      vt[i].e_empty = 1'b0;
      vt[i].e_ovf   = (i >= 16);
      vt[i].e_start = 1'b0;
    end
    vt[17] = '{1'b0, 8'hEE, 1'b1, 5'd16,
               1'b1, 1'b0, 1'b1, 1'b0};

    do_reset();
    use_model = 1'b0;
    for (int i = 0; i < 18; i++) begin
      f_busy      = vt[i].busy;
      bus.wr_en   = vt[i].wr_en;
      bus.wr_data = vt[i].data;
      tick();
      bus.wr_en = 1'b0;
      chk($sformatf("fill%0d_count", i),
          32'(bus.count), 32'(vt[i].e_count));
      chk($sformatf("fill%0d_full", i),
          32'(bus.full), 32'(vt[i].e_full));
      chk($sformatf("fill%0d_empty", i),
          32'(bus.empty), 32'(vt[i].e_empty));
      chk($sformatf("fill%0d_ovf", i),
          32'(bus.overflow), 32'(vt[i].e_ovf));
      chk($sformatf("fill%0d_start", i),
          32'(bus.tx_start), 32'(vt[i].e_start));
    end
    use_model = 1'b1;
    tick();
    chk("fill_pop_full", 32'(bus.full), 0);
    chk("fill_pop_count", 32'(bus.count), 15);
    chk("fill_pop_start", 32'(bus.tx_start), 1);
    wait_rx("fill_rx_wait", 16, 16 * (FRAME + 6) + 50);
    repeat (6) tick();
    chk("fill_rx_n", rxq.size(), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("fill_rx%0d", i),
          32'(rx_at(i)), 32'h20 + i);
    chk("fill_ovf_sticky", 32'(bus.overflow), 1);

    // Start timeout with tx_busy stuck low.
    do_reset();
    use_model = 1'b0;
    f_busy    = 1'b0;
    wr(8'h3C);
    tick();
    chk("tmo_start", 32'(bus.tx_start), 1);
    chk("tmo_data", 32'(bus.tx_data), 32'h3C);
    repeat (16) tick();
    chk("tmo_err_pre", 32'(bus.start_err), 0);
    tick();
    chk("tmo_err", 32'(bus.start_err), 1);
    chk("tmo_empty", 32'(bus.empty), 1);
    wr(8'h3D);
    tick();
    chk("tmo_relaunch", 32'(bus.tx_start), 1);
    chk("tmo_relaunch_data", 32'(bus.tx_data), 32'h3D);
    tick();
    chk("tmo_n_starts", start_e.size(), 2);
    chk("tmo_err_sticky", 32'(bus.start_err), 1);

    // Reset in the middle of a frame with bytes queued.
    do_reset();
    use_model = 1'b1;
    for (int i = 0; i < 6; i++) wr(8'(8'h51 + i));
    chk("mid_count", 32'(bus.count), 5);
    chk("mid_data", 32'(bus.tx_data), 32'h51);
    chk("mid_busy", 32'(bus.tx_busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_start", 32'(bus.tx_start), 0);
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_empty", 32'(bus.empty), 1);
    chk("mid_rst_data", 32'(bus.tx_data), 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
